// File: rtl/rom_loader.sv
// rom_loader: multi-slot ROM download controller feeding a toggle-handshake sdram write port.
// States: IDLE idle / power-up stretch | LOAD accept bytes | WAIT sdram ack | STRETCH core reset hold
module rom_loader #(
  parameter int ADDR_W    = 22,
  parameter int SLOTS     = 2,
  parameter int SLOT_W    = (SLOTS > 1) ? $clog2(SLOTS) : 0,
  parameter int HDR_BYTES = 512,
  parameter int RST_W     = 20,
  parameter int DATA_W    = 8,
  localparam int M        = ADDR_W - SLOT_W,
  localparam int SW       = (SLOT_W > 0) ? SLOT_W : 1
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic                  ce_cpu,
  input  logic                  ioctl_download,
  input  logic [7:0]            ioctl_index,
  input  logic                  ioctl_wr,
  input  logic [24:0]           ioctl_addr,
  input  logic [DATA_W-1:0]     ioctl_dout,
  output logic                  ioctl_wait,
  output logic [ADDR_W-1:0]     mem_waddr,
  output logic [DATA_W-1:0]     mem_din,
  output logic                  mem_we_req,
  input  logic                  mem_we_ack,
  input  logic [SW-1:0]         rd_slot,
  input  logic [M-1:0]          rd_addr,
  output logic [ADDR_W-1:0]     mem_raddr,
  output logic [SLOTS*M-1:0]    cart_mask,
  output logic [SLOTS-1:0]      hdr_present,
  output logic [SLOTS-1:0]      loaded,
  output logic                  sys_reset
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_STRETCH} state_t;

  state_t                 state_q, state_d;
  logic                   dl_q, dl_d;
  logic [RST_W-1:0]       cnt_q, cnt_d, cnt_dec;
  logic                   sys_reset_q, sys_reset_d;
  logic                   wait_q, wait_d;
  logic                   req_q, req_d;
  logic [ADDR_W-1:0]      waddr_q, waddr_d;
  logic [ADDR_W-1:0]      raddr_q, raddr_d;
  logic [DATA_W-1:0]      din_q, din_d;
  logic [SLOTS-1:0][M-1:0] mask_q, mask_d;
  logic [SLOTS-1:0]       hdr_q, hdr_d;
  logic [SLOTS-1:0]       loaded_q, loaded_d;
  logic [SW-1:0]          slot_q, slot_d;
  logic                   valid_q, valid_d;
  logic                   wrote_q, wrote_d;
  logic [24:0]            last_q, last_d;
  logic [SW-1:0]          idx_slot;
  logic                   idx_valid;
  logic                   hdr_hit;
  logic                   fin;
  logic [M-1:0]           rd_off;

  assign idx_slot  = ioctl_index[SW-1:0];
  // The whole index is compared so aliased indices (e.g. 3 with two slots) are rejected.
  assign idx_valid = ({24'd0, ioctl_index} < 32'(SLOTS));
  assign hdr_hit   = (10'(last_q + 25'd1) == 10'(HDR_BYTES % 1024));

  always_comb begin
    state_d     = state_q;
    dl_d        = ioctl_download;
    cnt_d       = cnt_q;
    sys_reset_d = sys_reset_q;
    wait_d      = wait_q;
    req_d       = req_q;
    waddr_d     = waddr_q;
    din_d       = din_q;
    mask_d      = mask_q;
    hdr_d       = hdr_q;
    loaded_d    = loaded_q;
    slot_d      = slot_q;
    valid_d     = valid_q;
    wrote_d     = wrote_q;
    last_d      = last_q;
    fin         = 1'b0;
    cnt_dec     = (ce_cpu && cnt_q != '0) ? cnt_q - RST_W'(1) : cnt_q;

    case (state_q)
      S_IDLE, S_STRETCH: begin
        cnt_d       = cnt_dec;
        sys_reset_d = (cnt_dec != '0);
        if (state_q == S_STRETCH && cnt_dec == '0)
          state_d = S_IDLE;
        if (ioctl_download && !dl_q) begin
          state_d     = S_LOAD;
          cnt_d       = '1;
          sys_reset_d = 1'b1;
          slot_d      = idx_slot;
          valid_d     = idx_valid;
          wrote_d     = 1'b0;
          if (idx_valid) begin
            mask_d[idx_slot]   = '0;
            hdr_d[idx_slot]    = 1'b0;
            loaded_d[idx_slot] = 1'b0;
          end
        end
      end
      S_LOAD: begin
        sys_reset_d = 1'b1;
        if (!ioctl_download) begin
          fin = 1'b1;
        end else if (ioctl_wr && valid_q) begin
          waddr_d        = ADDR_W'(ioctl_addr[M-1:0]) | (ADDR_W'(slot_q) << M);
          din_d          = ioctl_dout;
          req_d          = ~req_q;
          wait_d         = 1'b1;
          mask_d[slot_q] = mask_q[slot_q] | ioctl_addr[M-1:0];
          last_d         = ioctl_addr;
          wrote_d        = 1'b1;
          state_d        = S_WAIT;
        end
      end
      S_WAIT: begin
        sys_reset_d = 1'b1;
        if (mem_we_ack == req_q) begin
          wait_d = 1'b0;
          if (!ioctl_download)
            fin = 1'b1;
          else
            state_d = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (fin) begin
      state_d = S_STRETCH;
      if (valid_q) begin
        hdr_d[slot_q]    = wrote_q && hdr_hit;
        loaded_d[slot_q] = wrote_q;
      end
    end

    // Offset sum is M bits wide so it wraps without touching the slot field.
    rd_off  = '0;
    raddr_d = '0;
    if (32'(rd_slot) < 32'(SLOTS)) begin
      rd_off  = (rd_addr & mask_q[rd_slot]) + (hdr_q[rd_slot] ? M'(HDR_BYTES) : '0);
      raddr_d = ADDR_W'(rd_off) | (ADDR_W'(rd_slot) << M);
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      dl_q        <= 1'b0;
      cnt_q       <= '1;
      sys_reset_q <= 1'b1;
      wait_q      <= 1'b0;
      req_q       <= 1'b0;
      waddr_q     <= '0;
      raddr_q     <= '0;
      din_q       <= '0;
      mask_q      <= '0;
      hdr_q       <= '0;
      loaded_q    <= '0;
      slot_q      <= '0;
      valid_q     <= 1'b0;
      wrote_q     <= 1'b0;
      last_q      <= '0;
    end else begin
      state_q     <= state_d;
      dl_q        <= dl_d;
      cnt_q       <= cnt_d;
      sys_reset_q <= sys_reset_d;
      wait_q      <= wait_d;
      req_q       <= req_d;
      waddr_q     <= waddr_d;
      raddr_q     <= raddr_d;
      din_q       <= din_d;
      mask_q      <= mask_d;
      hdr_q       <= hdr_d;
      loaded_q    <= loaded_d;
      slot_q      <= slot_d;
      valid_q     <= valid_d;
      wrote_q     <= wrote_d;
      last_q      <= last_d;
    end
  end

  assign ioctl_wait  = wait_q;
  assign mem_waddr   = waddr_q;
  assign mem_din     = din_q;
  assign mem_we_req  = req_q;
  assign mem_raddr   = raddr_q;
  assign cart_mask   = mask_q;
  assign hdr_present = hdr_q;
  assign loaded      = loaded_q;
  assign sys_reset   = sys_reset_q;

endmodule
